// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings for the forwarding / hazard unit: operand-select codes and FSM states.
package fwd_hazard_unit_pkg;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_EXMEM = 2'd1,
    SEL_MEMWB = 2'd2,
    SEL_WBCAP = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LD_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source forward select: decides the producer in ID, registers it for EX, muxes the operand.
// FWD_WB_BYPASS_EN adds a WB-stage capture path for register files without write-through.
module fwd_src_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] rs,
  input  logic            rs_used,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
`ifdef FWD_WB_BYPASS_EN
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
`endif
  input  logic            freeze,
  input  logic            bubble,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] exmem_alu,
  input  logic [XLEN-1:0] memwb_wb,
  output logic            ex_hit,
  output logic [XLEN-1:0] op
);

  fwd_sel_e sel_d, sel_q;
  logic     mem_hit;

  assign ex_hit  = rs_used && (rs == ex_rd)  && (ex_rd  != '0) && ex_reg_write;
  assign mem_hit = rs_used && (rs == mem_rd) && (mem_rd != '0) && mem_reg_write;

`ifdef FWD_WB_BYPASS_EN
  logic            wb_hit;
  logic [XLEN-1:0] wb_cap_q;

  assign wb_hit = rs_used && (rs == wb_rd) && (wb_rd != '0) && wb_reg_write;
`endif

  // Younger producer wins: EX over MEM over WB.
  always_comb begin
    sel_d = SEL_NONE;
    if (ex_hit)       sel_d = SEL_EXMEM;
    else if (mem_hit) sel_d = SEL_MEMWB;
`ifdef FWD_WB_BYPASS_EN
    else if (wb_hit)  sel_d = SEL_WBCAP;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sel_q <= SEL_NONE;
    else if (!freeze) sel_q <= bubble ? SEL_NONE : sel_d;
  end

`ifdef FWD_WB_BYPASS_EN
  // The WB value retires this cycle, so it must be captured now for use in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          wb_cap_q <= '0;
    else if (!freeze && !bubble && sel_d == SEL_WBCAP)   wb_cap_q <= memwb_wb;
  end
`endif

  always_comb begin
    op = rf_data;
    case (sel_q)
      SEL_EXMEM: op = exmem_alu;
      SEL_MEMWB: op = memwb_wb;
`ifdef FWD_WB_BYPASS_EN
      SEL_WBCAP: op = wb_cap_q;
`endif
      default:   op = rf_data;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Pipeline forwarding and hazard control: load-use stall, flush bubble, memory freeze, stall counter.
// Optional WB capture bypass enabled by defining FWD_WB_BYPASS_EN.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int RA_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC*RA_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic [RA_W-1:0]         ex_rd,
  input  logic [RA_W-1:0]         mem_rd,
  input  logic [RA_W-1:0]         wb_rd,
  input  logic                    ex_reg_write,
  input  logic                    mem_reg_write,
  input  logic                    wb_reg_write,
  input  logic                    ex_mem_read,
  input  logic                    mem_busy,
  input  logic                    flush,
  input  logic [NUM_SRC*XLEN-1:0] ex_rf_data,
  input  logic [XLEN-1:0]         exmem_alu,
  input  logic [XLEN-1:0]         memwb_wb,
  output logic                    stall_fd,
  output logic                    bubble_ex,
  output logic                    freeze,
  output logic [NUM_SRC*XLEN-1:0] ex_op,
  output logic [1:0]              hz_state,
  output logic [15:0]             stall_cnt
);

  hz_state_e          state_q, state_d;
  logic [NUM_SRC-1:0] ex_hit;
  logic               load_use;

`ifndef FWD_WB_BYPASS_EN
  logic wb_unused;
  assign wb_unused = ^{wb_rd, wb_reg_write};
`endif

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_sel #(
      .XLEN (XLEN),
      .RA_W (RA_W)
    ) u_sel (
      .clk           (clk),
      .rst_n         (rst_n),
      .rs            (id_rs[k*RA_W +: RA_W]),
      .rs_used       (id_rs_used[k]),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
`ifdef FWD_WB_BYPASS_EN
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
`endif
      .freeze        (freeze),
      .bubble        (bubble_ex),
      .rf_data       (ex_rf_data[k*XLEN +: XLEN]),
      .exmem_alu     (exmem_alu),
      .memwb_wb      (memwb_wb),
      .ex_hit        (ex_hit[k]),
      .op            (ex_op[k*XLEN +: XLEN])
    );
  end

  assign load_use  = (|ex_hit) & ex_mem_read;
  assign freeze    = mem_busy;
  assign stall_fd  = mem_busy | (load_use & ~flush);
  assign bubble_ex = ~mem_busy & (flush | load_use);
  assign hz_state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HZ_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN: begin
        if (mem_busy)                  state_d = HZ_MEM_WAIT;
        else if (load_use && !flush)   state_d = HZ_LD_STALL;
      end
      HZ_LD_STALL: state_d = mem_busy ? HZ_MEM_WAIT : HZ_RUN;
      HZ_MEM_WAIT: if (!mem_busy) state_d = HZ_RUN;
      default:     state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         stall_cnt <= '0;
    else if (stall_fd && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
  end

`ifndef SYNTHESIS
  // One bubble must always resolve a load-use hazard; a second one means the stall logic is broken.
  a_no_double_load_use : assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == HZ_LD_STALL) |-> !load_use
  );
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding paths, load-use, flush, freeze and reset behaviour.
module tb_fwd_hazard_unit;

  localparam int XLEN = 32;
  localparam int NUM_SRC = 2;
  localparam int RA_W = 5;

  localparam logic [XLEN-1:0] RF0   = 32'hAAAA0000;
  localparam logic [XLEN-1:0] RF1   = 32'hBBBB1111;
  localparam logic [XLEN-1:0] EXMEM = 32'h00001234;
  localparam logic [XLEN-1:0] MEMWB = 32'h00005678;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_SRC*RA_W-1:0] id_rs;
  logic [NUM_SRC-1:0]      id_rs_used;
  logic [RA_W-1:0]         ex_rd, mem_rd, wb_rd;
  logic                    ex_reg_write, mem_reg_write, wb_reg_write;
  logic                    ex_mem_read, mem_busy, flush;
  logic [NUM_SRC*XLEN-1:0] ex_rf_data;
  logic [XLEN-1:0]         exmem_alu, memwb_wb;
  logic                    stall_fd, bubble_ex, freeze;
  logic [NUM_SRC*XLEN-1:0] ex_op;
  logic [1:0]              hz_state;
  logic [15:0]             stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .mem_busy(mem_busy), .flush(flush),
    .ex_rf_data(ex_rf_data), .exmem_alu(exmem_alu), .memwb_wb(memwb_wb),
    .stall_fd(stall_fd), .bubble_ex(bubble_ex), .freeze(freeze),
    .ex_op(ex_op), .hz_state(hz_state), .stall_cnt(stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rs_used = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    ex_mem_read = 1'b0; mem_busy = 1'b0; flush = 1'b0;
    ex_rf_data = {RF1, RF0}; exmem_alu = EXMEM; memwb_wb = MEMWB;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    total++; if (hz_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", hz_state); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    total++; if (ex_op !== {RF1, RF0}) begin bad++; $display("FAIL reset_op: got %h want %h", ex_op, {RF1, RF0}); end
    total++; if ({stall_fd, bubble_ex, freeze} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got %b want 000", {stall_fd, bubble_ex, freeze}); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_exmem_fwd();
    ex_rd = 5'd5; ex_reg_write = 1'b1; id_rs[4:0] = 5'd5; id_rs_used = 2'b01;
    #1;
    total++; if ({stall_fd, bubble_ex} !== 2'b00) begin bad++; $display("FAIL s1_nostall: got %b want 00", {stall_fd, bubble_ex}); end
    step();
    idle_inputs();
    #1;
    total++; if (ex_op[31:0] !== EXMEM) begin bad++; $display("FAIL s1_op0: got %h want %h", ex_op[31:0], EXMEM); end
    total++; if (ex_op[63:32] !== RF1) begin bad++; $display("FAIL s1_op1: got %h want %h", ex_op[63:32], RF1); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL s1_cnt: got %0d want 0", stall_cnt); end
    step();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd7; ex_reg_write = 1'b1; id_rs[9:5] = 5'd7; id_rs_used = 2'b10;
    #1;
    total++; if ({stall_fd, bubble_ex} !== 2'b11) begin bad++; $display("FAIL s2_stall: got %b want 11", {stall_fd, bubble_ex}); end
    step();
    // load moves to MEM, bubble now in EX; stalled instruction still in ID
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = '0; mem_rd = 5'd7; mem_reg_write = 1'b1;
    #1;
    total++; if (hz_state !== 2'd1) begin bad++; $display("FAIL s2_state: got %0d want 1", hz_state); end
    total++; if ({stall_fd, bubble_ex} !== 2'b00) begin bad++; $display("FAIL s2_release: got %b want 00", {stall_fd, bubble_ex}); end
    total++; if (ex_op[63:32] !== RF1) begin bad++; $display("FAIL s2_bubble_op: got %h want %h", ex_op[63:32], RF1); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL s2_cnt: got %0d want 1", stall_cnt); end
    step();
    idle_inputs();
    #1;
    total++; if (hz_state !== 2'd0) begin bad++; $display("FAIL s2_run: got %0d want 0", hz_state); end
    total++; if (ex_op[63:32] !== MEMWB) begin bad++; $display("FAIL s2_op1: got %h want %h", ex_op[63:32], MEMWB); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL s2_cnt2: got %0d want 1", stall_cnt); end
    step();
  endtask

  task automatic test_priority_and_x0();
    ex_rd = 5'd3; mem_rd = 5'd3; ex_reg_write = 1'b1; mem_reg_write = 1'b1;
    id_rs[4:0] = 5'd3; id_rs_used = 2'b01;
    step();
    idle_inputs();
    #1;
    total++; if (ex_op[31:0] !== EXMEM) begin bad++; $display("FAIL s3_young: got %h want %h", ex_op[31:0], EXMEM); end
    ex_reg_write = 1'b1; mem_reg_write = 1'b1; wb_reg_write = 1'b1; id_rs_used = 2'b11;
    step();
    #1;
    total++; if (ex_op !== {RF1, RF0}) begin bad++; $display("FAIL s3b_x0: got %h want %h", ex_op, {RF1, RF0}); end
    idle_inputs();
    ex_rd = 5'd5; ex_reg_write = 1'b1; id_rs[4:0] = 5'd5; id_rs_used = 2'b00;
    step();
    #1;
    total++; if (ex_op[31:0] !== RF0) begin bad++; $display("FAIL s3c_unused: got %h want %h", ex_op[31:0], RF0); end
    idle_inputs();
    mem_rd = 5'd12; mem_reg_write = 1'b1; id_rs[9:5] = 5'd12; id_rs_used = 2'b10;
    step();
    idle_inputs();
    #1;
    total++; if (ex_op[63:32] !== MEMWB) begin bad++; $display("FAIL s3d_mem: got %h want %h", ex_op[63:32], MEMWB); end
    step();
  endtask

  task automatic test_flush_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd9; ex_reg_write = 1'b1; id_rs[4:0] = 5'd9; id_rs_used = 2'b01; flush = 1'b1;
    #1;
    total++; if ({stall_fd, bubble_ex} !== 2'b01) begin bad++; $display("FAIL s4_ctl: got %b want 01", {stall_fd, bubble_ex}); end
    step();
    idle_inputs();
    #1;
    total++; if (hz_state !== 2'd0) begin bad++; $display("FAIL s4_state: got %0d want 0", hz_state); end
    total++; if (ex_op[31:0] !== RF0) begin bad++; $display("FAIL s4_op: got %h want %h", ex_op[31:0], RF0); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL s4_cnt: got %0d want 1", stall_cnt); end
    step();
  endtask

  task automatic test_mem_busy();
    ex_rd = 5'd4; ex_reg_write = 1'b1; id_rs[4:0] = 5'd4; id_rs_used = 2'b01;
    step();
    idle_inputs();
    mem_busy = 1'b1; mem_rd = 5'd6; mem_reg_write = 1'b1; id_rs[4:0] = 5'd6; id_rs_used = 2'b01;
    #1;
    total++; if ({freeze, stall_fd, bubble_ex} !== 3'b110) begin bad++; $display("FAIL s5_ctl: got %b want 110", {freeze, stall_fd, bubble_ex}); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (hz_state !== 2'd2) begin bad++; $display("FAIL s5_state%0d: got %0d want 2", i, hz_state); end
      total++; if (ex_op[31:0] !== EXMEM) begin bad++; $display("FAIL s5_hold%0d: got %h want %h", i, ex_op[31:0], EXMEM); end
    end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL s5_cnt: got %0d want 4", stall_cnt); end
    mem_busy = 1'b0;
    #1;
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL s5_unfreeze: got %b want 0", freeze); end
    step();
    idle_inputs();
    #1;
    total++; if (hz_state !== 2'd0) begin bad++; $display("FAIL s5_run: got %0d want 0", hz_state); end
    total++; if (ex_op[31:0] !== MEMWB) begin bad++; $display("FAIL s5_op: got %h want %h", ex_op[31:0], MEMWB); end
    step();
  endtask

  task automatic test_wb_path();
    wb_rd = 5'd8; wb_reg_write = 1'b1; id_rs[4:0] = 5'd8; id_rs_used = 2'b01;
    step();
    idle_inputs();
    memwb_wb = 32'h99999999;
    #1;
`ifdef FWD_WB_BYPASS_EN
    total++; if (ex_op[31:0] !== MEMWB) begin bad++; $display("FAIL wb_cap: got %h want %h", ex_op[31:0], MEMWB); end
`else
    total++; if (ex_op[31:0] !== RF0) begin bad++; $display("FAIL wb_none: got %h want %h", ex_op[31:0], RF0); end
`endif
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_stall();
    ex_mem_read = 1'b1; ex_rd = 5'd10; ex_reg_write = 1'b1; id_rs[4:0] = 5'd10; id_rs_used = 2'b01;
    step();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = '0; mem_rd = 5'd10; mem_reg_write = 1'b1;
    #1;
    total++; if (hz_state !== 2'd1) begin bad++; $display("FAIL s6_pre: got %0d want 1", hz_state); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (hz_state !== 2'd0) begin bad++; $display("FAIL s6_state: got %0d want 0", hz_state); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL s6_cnt: got %0d want 0", stall_cnt); end
    total++; if (ex_op !== {RF1, RF0}) begin bad++; $display("FAIL s6_op: got %h want %h", ex_op, {RF1, RF0}); end
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();
    total++; if ({hz_state, stall_fd} !== 3'b000) begin bad++; $display("FAIL s6_after: got %b want 000", {hz_state, stall_fd}); end
  endtask

  initial begin
    test_reset();
    test_exmem_fwd();
    test_load_use();
    test_priority_and_x0();
    test_flush_load_use();
    test_mem_busy();
    test_wb_path();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, datapath width; NUM_SRC, 2, source operands per instruction; RA_W, 5, register-address width.
REQ-002 Ports, one per line (name, direction, width, meaning); the clock is clk and the reset is rst_n.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs  in  NUM_SRC*RA_W  source register addresses of the instruction in ID; slot k occupies bits [k*RA_W +: RA_W].
REQ-006 id_rs_used  in  NUM_SRC  per-source valid flag for the ID instruction.
REQ-007 ex_rd, mem_rd, wb_rd  in  RA_W each  destination register of the instruction in EX, MEM and WB respectively.
REQ-008 ex_reg_write, mem_reg_write, wb_reg_write  in  1 each  write enable of the EX, MEM and WB instruction.
REQ-009 ex_mem_read  in  1  the instruction in EX is a load.
REQ-010 mem_busy  in  1  data memory is not ready; the whole pipeline freezes.
REQ-011 flush  in  1  taken branch or jump; squashes ID.
REQ-012 ex_rf_data  in  NUM_SRC*XLEN  register-file operands already latched into ID/EX.
REQ-013 exmem_alu, memwb_wb  in  XLEN each  forwarding sources from EX/MEM and MEM/WB.
REQ-014 stall_fd  out  1  hold PC and IF/ID.
REQ-015 bubble_ex  out  1  load a NOP into ID/EX.
REQ-016 freeze  out  1  hold all pipeline registers.
REQ-017 ex_op  out  NUM_SRC*XLEN  resolved EX operands.
REQ-018 hz_state  out  2  FSM state, for debug.
REQ-019 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-020 match(k, X) SHALL be: id_rs_used[k] && id_rs[k]==X_rd && X_rd!=0 && X_reg_write.
REQ-021 load_use SHALL be the OR over k of (match(k, ex) && ex_mem_read); it is combinational.
REQ-022 Output priority SHALL be mem_busy > flush > load_use:
- freeze = mem_busy.
- stall_fd = mem_busy | (load_use & ~flush).
- bubble_ex = ~mem_busy & (flush | load_use).
REQ-023 The forward select for each source SHALL be computed in ID and registered into sel_q[k] (NONE/EXMEM/MEMWB, 2 bits), ready for the instruction's EX cycle.
REQ-024 The next value of sel_q[k] SHALL be EXMEM if match(k, ex), else MEMWB if match(k, mem), else NONE; the younger producer wins.
REQ-025 While freeze is high, sel_q SHALL hold its value.
REQ-026 When bubble_ex is high, sel_q SHALL load NONE.
REQ-027 ex_op[k] SHALL be combinational from sel_q[k]: exmem_alu for EXMEM, memwb_wb for MEMWB, ex_rf_data[k] for NONE.
REQ-028 A load-use hazard SHALL cost exactly one bubble. In the next cycle the load is in MEM, the recomputed select is MEMWB, and no second stall occurs.
REQ-029 FSM states SHALL be RUN=0, LD_STALL=1, MEM_WAIT=2.
REQ-030 FSM transitions SHALL be:
- RUN to MEM_WAIT on mem_busy, else to LD_STALL on load_use & ~flush.
- LD_STALL to MEM_WAIT on mem_busy, else to RUN unconditionally.
- MEM_WAIT to RUN on ~mem_busy.
REQ-031 A load_use asserted in LD_STALL SHALL be a design error; it is flagged by an assertion in simulation only.
REQ-032 stall_cnt SHALL increment each cycle stall_fd is high and saturate at 16'hFFFF.

Reset
REQ-033 On rst_n low, asynchronously: sel_q = NONE for all k, state = RUN, stall_cnt = 0, WB capture register = 0.
REQ-034 Combinational outputs SHALL follow from the reset state. Reset asserted mid-stall SHALL abandon the stall with no residue.

Configuration
REQ-035 Macro FWD_WB_BYPASS_EN SHALL control a fourth select value, WBCAP.
REQ-036 With FWD_WB_BYPASS_EN defined: a match(k, wb) with no EX or MEM match SHALL select WBCAP. Memwb_wb is captured into wb_cap_q in that ID cycle, and ex_op[k] = wb_cap_q. This covers a register file without write-through.
REQ-037 Without FWD_WB_BYPASS_EN: WB is never matched, wb_cap_q is absent, and the register file SHALL be write-through.

Structure
REQ-038 The shared package SHALL hold the select encodings (NONE=0, EXMEM=1, MEMWB=2, WBCAP=3) and the FSM state encodings.
REQ-039 Per-source select logic SHALL be one sub-module, fwd_src_sel, instantiated NUM_SRC times by a generate loop.

Verification
REQ-040 Scenario 1: ex_rd=5, ex_reg_write=1, id_rs[0]=5, then advance one cycle; expect ex_op[0]=exmem_alu=32'h1234 and no stall.
REQ-041 Scenario 2: ex_mem_read=1, ex_rd=7, id_rs[1]=7; expect stall_fd=1 and bubble_ex=1 for exactly 1 cycle, hz_state=LD_STALL, then ex_op[1]=memwb_wb.
REQ-042 Scenario 3: ex_rd=mem_rd=3, both writing, id_rs[0]=3; expect sel EXMEM.
REQ-043 Scenario 3b: id_rs[0]=0 with writers on x0; expect ex_rf_data passes through.
REQ-044 Scenario 4: load_use and flush in the same cycle; expect bubble_ex=1, stall_fd=0, state stays RUN.
REQ-045 Scenario 5: mem_busy high for 3 cycles during a forward; expect freeze=1, sel_q held, hz_state=MEM_WAIT, stall_cnt +3.
REQ-046 Scenario 6: rst_n low during LD_STALL; expect state=RUN, sel_q=NONE, stall_cnt=0 immediately.
